// File: rtl/alu_vec_reg.sv
// -----------------------------------------------------------------------------
// alu_vec_reg
//   Registered SIMD vector ALU. Both vector operands are split into
//   NUM_INSTANCES independent lanes of BITS_INDEX bits. One opcode is applied
//   to every lane in parallel, or the scalar c is broadcast to every lane.
//   Per-lane results and {N,Z,C,V} flags are registered for writeback.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset (clears result and flags)
//   a, b    in   WIDTH_V vector operands; lane i = x[BITS_INDEX*i +: BITS_INDEX]
//   c       in   BITS_INDEX scalar for SET (whole value) and SHL (c[2:0])
//   opcode  in   3-bit operation select
//   result  out  registered lane results, same lane mapping as a
//   flags   out  registered flags; flags[4i+3:4i] = {N,Z,C,V} of lane i
// -----------------------------------------------------------------------------
module alu_vec_reg #(
    parameter  int WIDTH_V       = 128,
    parameter  int BITS_INDEX    = 8,
    localparam int NUM_INSTANCES = WIDTH_V / BITS_INDEX
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH_V-1:0]         a,
    input  logic [WIDTH_V-1:0]         b,
    input  logic [BITS_INDEX-1:0]      c,
    input  logic [2:0]                 opcode,
    output logic [WIDTH_V-1:0]         result,
    output logic [NUM_INSTANCES*4-1:0] flags
);

    typedef enum logic [2:0] {
        OP_MUL = 3'b000,
        OP_SUB = 3'b001,
        OP_ADD = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SET = 3'b111
    } op_e;

    localparam int B = BITS_INDEX;

    op_e                       w_op;
    logic [WIDTH_V-1:0]        w_result;
    logic [NUM_INSTANCES*4-1:0] w_flags;
    logic [2:0]                w_sh;

    logic [WIDTH_V-1:0]         r_result;
    logic [NUM_INSTANCES*4-1:0] r_flags;

    assign w_op = op_e'(opcode);
    assign w_sh = c[2:0];

    for (genvar g = 0; g < NUM_INSTANCES; g++) begin : g_lane
        logic [B-1:0]          w_x;
        logic [B-1:0]          w_y;
        logic signed [2*B-1:0] w_prod;
        logic                  w_mul_ovf;
        logic [B:0]            w_sum;
        logic [B:0]            w_diff;
        logic [B:0]            w_shl;
        logic [B-1:0]          w_res;
        logic                  w_c;
        logic                  w_v;

        assign w_x = a[B*g +: B];
        assign w_y = b[B*g +: B];

        // Operands are sign-extended to the full product width before the multiply.
        assign w_prod    = $signed(w_x) * $signed(w_y);
        // Product fits in B signed bits only if the upper half is a pure sign extension.
        assign w_mul_ovf = (w_prod != {{B{w_prod[B-1]}}, w_prod[B-1:0]});

        // One extra bit captures carry (ADD) or borrow (SUB) without leaking into the next lane.
        assign w_sum  = {1'b0, w_x} + {1'b0, w_y};
        assign w_diff = {1'b0, w_x} - {1'b0, w_y};
        // Bit B of the widened shift holds the last bit shifted out of the lane.
        assign w_shl  = {1'b0, w_x} << w_sh;

        always_comb begin
            // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
            w_res = '0;
            w_c   = 1'b0;
            w_v   = 1'b0;
            case (w_op)
                OP_MUL: begin
                    w_res = w_prod[B-1:0];
                    w_c   = w_mul_ovf;
                    w_v   = w_mul_ovf;
                end
                OP_SUB: begin
                    w_res = w_diff[B-1:0];
                    w_c   = ~w_diff[B];
                    w_v   = (w_x[B-1] ^ w_y[B-1]) & (w_diff[B-1] ^ w_x[B-1]);
                end
                OP_ADD: begin
                    w_res = w_sum[B-1:0];
                    w_c   = w_sum[B];
                    w_v   = ~(w_x[B-1] ^ w_y[B-1]) & (w_sum[B-1] ^ w_x[B-1]);
                end
                OP_AND: w_res = w_x & w_y;
                OP_OR:  w_res = w_x | w_y;
                OP_XOR: w_res = w_x ^ w_y;
                OP_SHL: begin
                    w_res = w_shl[B-1:0];
                    w_c   = (w_sh != 3'd0) & w_shl[B];
                end
                OP_SET: w_res = c;
                default: ;
            endcase
        end

        assign w_result[B*g +: B] = w_res;
        assign w_flags[4*g +: 4]  = {w_res[B-1], ~|w_res, w_c, w_v};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

    assign result = r_result;
    assign flags  = r_flags;

endmodule

// File: tb/tb_alu_vec_reg.sv
// -----------------------------------------------------------------------------
// tb_alu_vec_reg
//   Self-checking bench for alu_vec_reg (128-bit vector, 8-bit lanes).
//   Expected results are pushed to a queue when stimulus is driven and popped
//   and compared one clock later when the registered output is valid.
//   Directed vectors carry hand-computed expectations; random vectors use an
//   integer reference model of the lane arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_vec_reg;

    localparam int WV = 128;
    localparam int BI = 8;
    localparam int NL = WV / BI;

    typedef struct packed {
        logic [WV-1:0]   res;
        logic [NL*4-1:0] flg;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [WV-1:0]   a;
    logic [WV-1:0]   b;
    logic [BI-1:0]   c;
    logic [2:0]      opcode;
    logic [WV-1:0]   result;
    logic [NL*4-1:0] flags;

    exp_t q_exp[$];
    int   n_vectors;
    int   n_miscompares;

    alu_vec_reg #(.WIDTH_V(WV), .BITS_INDEX(BI)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .c      (c),
        .opcode (opcode),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [WV-1:0] got, input logic [WV-1:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [WV-1:0] rep8(input logic [7:0] v);
        return {NL{v}};
    endfunction

    function automatic logic [NL*4-1:0] rep4(input logic [3:0] v);
        return {NL{v}};
    endfunction

    // Integer reference model: overflow judged by range of the exact signed result.
    function automatic exp_t model(input logic [WV-1:0] av, input logic [WV-1:0] bv,
                                   input logic [7:0] cv, input logic [2:0] op);
        exp_t e;
        e = '0;
        for (int i = 0; i < NL; i++) begin
            int x, y, sx, sy, full, r, sh;
            bit cf, vf;
            x  = int'(av[8*i +: 8]);
            y  = int'(bv[8*i +: 8]);
            sx = (x >= 128) ? x - 256 : x;
            sy = (y >= 128) ? y - 256 : y;
            cf = 1'b0;
            vf = 1'b0;
            r  = 0;
            case (op)
                3'b000: begin
                    full = sx * sy;
                    r    = full & 255;
                    cf   = (full > 127) || (full < -128);
                    vf   = cf;
                end
                3'b001: begin
                    r    = (x - y) & 255;
                    cf   = (x >= y);
                    full = sx - sy;
                    vf   = (full > 127) || (full < -128);
                end
                3'b010: begin
                    r    = (x + y) & 255;
                    cf   = (x + y) > 255;
                    full = sx + sy;
                    vf   = (full > 127) || (full < -128);
                end
                3'b011: r = x & y;
                3'b100: r = x | y;
                3'b101: r = x ^ y;
                3'b110: begin
                    sh = int'(cv[2:0]);
                    r  = (x << sh) & 255;
                    cf = (sh != 0) ? bit'((x >> (8 - sh)) & 1) : 1'b0;
                end
                default: r = int'(cv);
            endcase
            e.res[8*i +: 8] = r[7:0];
            e.flg[4*i +: 4] = {r[7], (r == 0), cf, vf};
        end
        return e;
    endfunction

    // Drive one vector on the falling edge, queue its expectation, then
    // compare just after the rising edge that registers it.
    task automatic apply(input string tag, input logic [WV-1:0] av, input logic [WV-1:0] bv,
                         input logic [7:0] cv, input logic [2:0] op, input exp_t e);
        exp_t got_e;
        @(negedge clk);
        a      = av;
        b      = bv;
        c      = cv;
        opcode = op;
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            n_vectors++;
            n_miscompares++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            got_e = q_exp.pop_front();
            check({tag, ".res"}, result, got_e.res);
            check({tag, ".flg"}, WV'(flags), WV'(got_e.flg));
        end
    endtask

    task automatic apply_lit(input string tag, input logic [WV-1:0] av, input logic [WV-1:0] bv,
                             input logic [7:0] cv, input logic [2:0] op,
                             input logic [WV-1:0] er, input logic [NL*4-1:0] ef);
        exp_t e;
        e.res = er;
        e.flg = ef;
        apply(tag, av, bv, cv, op, e);
    endtask

    task automatic apply_mod(input string tag, input logic [WV-1:0] av, input logic [WV-1:0] bv,
                             input logic [7:0] cv, input logic [2:0] op);
        apply(tag, av, bv, cv, op, model(av, bv, cv, op));
    endtask

    initial begin
        logic [WV-1:0] ra, rb;
        n_vectors     = 0;
        n_miscompares = 0;
        a      = '0;
        b      = '0;
        c      = '0;
        opcode = 3'b000;
        rst_n  = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset.res", result, '0);
        check("reset.flg", WV'(flags), '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed expectations.
        apply_lit("add10_20", rep8(8'd10), rep8(8'd20), 8'd0, 3'b010, rep8(8'h1E), rep4(4'b0000));
        apply_lit("sub50_20", rep8(8'd50), rep8(8'd20), 8'd0, 3'b001, rep8(8'h1E), rep4(4'b0010));
        apply_lit("sub20_50", rep8(8'd20), rep8(8'd50), 8'd0, 3'b001, rep8(8'hE2), rep4(4'b1000));
        apply_lit("mul5_6",   rep8(8'd5),  rep8(8'd6),  8'd0, 3'b000, rep8(8'h1E), rep4(4'b0000));
        apply_lit("mul16_16", rep8(8'd16), rep8(8'd16), 8'd0, 3'b000, rep8(8'h00), rep4(4'b0111));
        apply_lit("set42",    '0, '0, 8'd42, 3'b111, rep8(8'h2A), rep4(4'b0000));
        apply_lit("set0",     rep8(8'h5A), rep8(8'hA5), 8'd0, 3'b111, '0, rep4(4'b0100));
        apply_lit("ovf_lane0", WV'(8'd127), WV'(8'd1), 8'd0, 3'b010,
                  WV'(8'h80), {{(NL-1){4'b0100}}, 4'b1001});
        apply_lit("carry_lane0", WV'(8'd255), WV'(8'd1), 8'd0, 3'b010,
                  '0, {{(NL-1){4'b0100}}, 4'b0110});
        apply_lit("borrow_lane0", '0, WV'(8'd1), 8'd0, 3'b001,
                  {{(NL-1){8'h00}}, 8'hFF}, {{(NL-1){4'b0110}}, 4'b1000});
        apply_lit("shl_by0",  rep8(8'h81), '0, 8'd0,   3'b110, rep8(8'h81), rep4(4'b1000));
        apply_lit("shl_by1",  rep8(8'h81), '0, 8'hF9, 3'b110, rep8(8'h02), rep4(4'b0010));
        apply_lit("shl_by7",  rep8(8'h03), '0, 8'd7,   3'b110, rep8(8'h80), rep4(4'b1010));
        apply_lit("and",      rep8(8'hF0), rep8(8'h3C), 8'd0, 3'b011, rep8(8'h30), rep4(4'b0000));
        apply_lit("or",       rep8(8'hF0), rep8(8'h0C), 8'd0, 3'b100, rep8(8'hFC), rep4(4'b1000));
        apply_lit("xor",      rep8(8'hAA), rep8(8'hAA), 8'd0, 3'b101, '0, rep4(4'b0100));
        apply_lit("mul_neg",  rep8(8'hFF), rep8(8'h80), 8'd0, 3'b000, rep8(8'h80), rep4(4'b1011));

        // Random vectors across all opcodes, checked against the model.
        for (int i = 0; i < 48; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            apply_mod("rand", ra, rb, 8'($urandom), 3'(i % 8));
        end

        // Asynchronous reset in the middle of ADD traffic.
        apply_lit("pre_rst_add", rep8(8'd10), rep8(8'd20), 8'd0, 3'b010, rep8(8'h1E), rep4(4'b0000));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async.res", result, '0);
        check("rst_async.flg", WV'(flags), '0);
        @(posedge clk);
        #1;
        check("rst_hold.res", result, '0);
        check("rst_hold.flg", WV'(flags), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_resume.res", result, rep8(8'h1E));
        check("rst_resume.flg", WV'(flags), WV'(rep4(4'b0000)));
        apply_lit("post_rst_sub", rep8(8'd20), rep8(8'd50), 8'd0, 3'b001, rep8(8'hE2), rep4(4'b1000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
